msm_point_accumulator: RTL and testbench

- Downstream of the scalar-multiplication stage.
- Consumes a stream of N curve points (the k_i·P_i products) over a valid/ready handshake and accumulates their sum, forming the final MSM result.
- Buffers inputs in a small FIFO so upstream multipliers can retire while an addition is in flight.
- Uses one shared point_add and one point_double instance; handles the point-at-infinity and equal/opposite-point exceptions in-block.

---
 rtl/elliptic_curve_structs.sv | 59 +++++
 rtl/msm_point_fifo.sv | 64 ++++++
 rtl/point_add.sv | 79 +++++++
 rtl/point_double.sv | 75 +++++++
 rtl/msm_point_accumulator.sv | 166 ++++++++++++++++
 tb/tb_msm_point_accumulator.sv | 230 +++++++++++++++++++++++
 6 files changed

// File: rtl/elliptic_curve_structs.sv
// Shared curve types and field helpers for the MSM datapath. The curve is y^2 = x^3 + 2x + 3 over GF(97).
// (0,0) is not on the curve, so it serves as the point at infinity.
package elliptic_curve_structs;

    localparam int SCALAR_WIDTH = 8;
    localparam int INV_IDX_W    = $clog2(SCALAR_WIDTH);

    localparam logic [SCALAR_WIDTH-1:0] FIELD_P = 8'd97;
    localparam logic [SCALAR_WIDTH-1:0] CURVE_A = 8'd2;
    localparam logic [SCALAR_WIDTH-1:0] INV_EXP = FIELD_P - 8'd2;

    typedef struct packed {
        logic [SCALAR_WIDTH-1:0] x;
        logic [SCALAR_WIDTH-1:0] y;
    } curve_point_t;

    localparam curve_point_t inf_point = '{x: '0, y: '0};

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ADD,
        WAIT_DBL,
        DONE
    } msm_acc_state_t;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_INV,
        OP_FIN
    } ec_op_state_t;

    function automatic logic point_eq(input curve_point_t a, input curve_point_t b);
        return (a.x == b.x) && (a.y == b.y);
    endfunction

    function automatic logic [SCALAR_WIDTH-1:0] mod_mul(input logic [SCALAR_WIDTH-1:0] a,
                                                        input logic [SCALAR_WIDTH-1:0] b);
        logic [2*SCALAR_WIDTH-1:0] prod;
        prod = (2*SCALAR_WIDTH)'(a) * (2*SCALAR_WIDTH)'(b);
        return SCALAR_WIDTH'(prod % (2*SCALAR_WIDTH)'(FIELD_P));
    endfunction

    function automatic logic [SCALAR_WIDTH-1:0] mod_add(input logic [SCALAR_WIDTH-1:0] a,
                                                        input logic [SCALAR_WIDTH-1:0] b);
        logic [SCALAR_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FIELD_P}) begin
            s = s - {1'b0, FIELD_P};
        end
        return s[SCALAR_WIDTH-1:0];
    endfunction

    function automatic logic [SCALAR_WIDTH-1:0] mod_sub(input logic [SCALAR_WIDTH-1:0] a,
                                                        input logic [SCALAR_WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (a + (FIELD_P - b));
    endfunction

endpackage

// File: rtl/msm_point_fifo.sv
// Small input buffer of curve points so upstream multipliers can retire while an
// addition is in flight. Push when full and pop when empty are ignored.
module msm_point_fifo
    import elliptic_curve_structs::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          flush,
    input  logic          push,
    input  curve_point_t  push_data,
    input  logic          pop,
    output curve_point_t  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    curve_point_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/point_add.sv
// Affine point addition for distinct-x operands; the slope inverse is computed by
// Fermat exponentiation, one exponent bit per cycle. Done stays high until the next Start.
module point_add
    import elliptic_curve_structs::*;
(
    input  logic         clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  curve_point_t A,
    input  curve_point_t B,
    output curve_point_t Result,
    output logic         Done
);

    ec_op_state_t            state;
    curve_point_t            a_q;
    curve_point_t            b_q;
    logic [SCALAR_WIDTH-1:0] base;
    logic [SCALAR_WIDTH-1:0] pow;
    logic [SCALAR_WIDTH-1:0] num;
    logic [SCALAR_WIDTH-1:0] sq;
    logic [SCALAR_WIDTH-1:0] step;
    logic [SCALAR_WIDTH-1:0] lambda;
    logic [SCALAR_WIDTH-1:0] x3;
    logic [SCALAR_WIDTH-1:0] y3;
    logic [INV_IDX_W-1:0]    bit_idx;

    always_comb begin
        sq     = mod_mul(pow, pow);
        step   = INV_EXP[bit_idx] ? mod_mul(sq, base) : sq;
        lambda = mod_mul(num, pow);
        x3     = mod_sub(mod_sub(mod_mul(lambda, lambda), a_q.x), b_q.x);
        y3     = mod_sub(mod_mul(lambda, mod_sub(a_q.x, x3)), a_q.y);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= OP_IDLE;
            a_q     <= inf_point;
            b_q     <= inf_point;
            base    <= '0;
            pow     <= '0;
            num     <= '0;
            bit_idx <= '0;
            Result  <= inf_point;
            Done    <= 1'b0;
        end else begin
            case (state)
                OP_IDLE: begin
                    if (Start) begin
                        a_q     <= A;
                        b_q     <= B;
                        base    <= mod_sub(B.x, A.x);
                        num     <= mod_sub(B.y, A.y);
                        pow     <= SCALAR_WIDTH'(1);
                        bit_idx <= INV_IDX_W'(SCALAR_WIDTH - 1);
                        Done    <= 1'b0;
                        state   <= OP_INV;
                    end
                end
                OP_INV: begin
                    pow <= step;
                    if (bit_idx == '0) begin
                        state <= OP_FIN;
                    end else begin
                        bit_idx <= bit_idx - INV_IDX_W'(1);
                    end
                end
                OP_FIN: begin
                    Result <= '{x: x3, y: y3};
                    Done   <= 1'b1;
                    state  <= OP_IDLE;
                end
                default: state <= OP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/point_double.sv
// Affine point doubling (operand y must be non-zero); same iterative inverse as point_add.
// Done stays high until the next Start.
module point_double
    import elliptic_curve_structs::*;
(
    input  logic         clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  curve_point_t A,
    output curve_point_t Result,
    output logic         Done
);

    ec_op_state_t            state;
    curve_point_t            a_q;
    logic [SCALAR_WIDTH-1:0] base;
    logic [SCALAR_WIDTH-1:0] pow;
    logic [SCALAR_WIDTH-1:0] num;
    logic [SCALAR_WIDTH-1:0] sq;
    logic [SCALAR_WIDTH-1:0] step;
    logic [SCALAR_WIDTH-1:0] lambda;
    logic [SCALAR_WIDTH-1:0] x3;
    logic [SCALAR_WIDTH-1:0] y3;
    logic [INV_IDX_W-1:0]    bit_idx;

    always_comb begin
        sq     = mod_mul(pow, pow);
        step   = INV_EXP[bit_idx] ? mod_mul(sq, base) : sq;
        lambda = mod_mul(num, pow);
        x3     = mod_sub(mod_sub(mod_mul(lambda, lambda), a_q.x), a_q.x);
        y3     = mod_sub(mod_mul(lambda, mod_sub(a_q.x, x3)), a_q.y);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= OP_IDLE;
            a_q     <= inf_point;
            base    <= '0;
            pow     <= '0;
            num     <= '0;
            bit_idx <= '0;
            Result  <= inf_point;
            Done    <= 1'b0;
        end else begin
            case (state)
                OP_IDLE: begin
                    if (Start) begin
                        a_q     <= A;
                        base    <= mod_add(A.y, A.y);
                        num     <= mod_add(mod_mul(SCALAR_WIDTH'(3), mod_mul(A.x, A.x)), CURVE_A);
                        pow     <= SCALAR_WIDTH'(1);
                        bit_idx <= INV_IDX_W'(SCALAR_WIDTH - 1);
                        Done    <= 1'b0;
                        state   <= OP_INV;
                    end
                end
                OP_INV: begin
                    pow <= step;
                    if (bit_idx == '0) begin
                        state <= OP_FIN;
                    end else begin
                        bit_idx <= bit_idx - INV_IDX_W'(1);
                    end
                end
                OP_FIN: begin
                    Result <= '{x: x3, y: y3};
                    Done   <= 1'b1;
                    state  <= OP_IDLE;
                end
                default: state <= OP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/msm_point_accumulator.sv
// Final MSM stage: sums N streamed curve points using one shared adder and one doubler,
// resolving infinity and equal/opposite operands locally.
module msm_point_accumulator
    import elliptic_curve_structs::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic [COUNT_WIDTH-1:0] N,
    input  logic                   In_valid,
    input  curve_point_t           In_point,
    output logic                   In_ready,
    output curve_point_t           Sum,
    output logic                   Done,
    output logic                   Busy
);

    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    msm_acc_state_t         state;
    curve_point_t           acc;
    curve_point_t           op_a;
    curve_point_t           op_b;
    curve_point_t           head;
    curve_point_t           add_result;
    curve_point_t           dbl_result;
    logic [COUNT_WIDTH-1:0] n_q;
    logic [COUNT_WIDTH-1:0] accepted;
    logic [COUNT_WIDTH-1:0] consumed;
    logic                   add_start_q;
    logic                   dbl_start_q;
    logic                   add_start;
    logic                   dbl_start;
    logic                   add_done;
    logic                   dbl_done;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_CW-1:0]     fifo_count;
    logic                   start_ok;
    logic                   push;
    logic                   pop;

    assign start_ok  = Start && ((state == IDLE) || (state == DONE));
    assign In_ready  = Busy && !fifo_full && (accepted < n_q);
    assign push      = In_valid && In_ready;
    assign pop       = (state == FETCH) && !fifo_empty;
    assign Sum       = acc;
    assign add_start = !Reset_n || add_start_q;
    assign dbl_start = !Reset_n || dbl_start_q;

    msm_point_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .flush     (start_ok),
        .push      (push),
        .push_data (In_point),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    point_add u_add (
        .clk     (clk),
        .Reset_n (Reset_n),
        .Start   (add_start),
        .A       (op_a),
        .B       (op_b),
        .Result  (add_result),
        .Done    (add_done)
    );

    point_double u_dbl (
        .clk     (clk),
        .Reset_n (Reset_n),
        .Start   (dbl_start),
        .A       (op_a),
        .Result  (dbl_result),
        .Done    (dbl_done)
    );

    // Sub-module Done is ignored while our start pulse is still high, since it may be stale from the previous op.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            acc         <= inf_point;
            op_a        <= inf_point;
            op_b        <= inf_point;
            n_q         <= '0;
            accepted    <= '0;
            consumed    <= '0;
            add_start_q <= 1'b0;
            dbl_start_q <= 1'b0;
            Done        <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            add_start_q <= 1'b0;
            dbl_start_q <= 1'b0;
            if (push) begin
                accepted <= accepted + COUNT_WIDTH'(1);
            end
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        n_q      <= N;
                        acc      <= inf_point;
                        accepted <= '0;
                        consumed <= '0;
                        if (N == '0) begin
                            state <= DONE;
                            Done  <= 1'b1;
                            Busy  <= 1'b0;
                        end else begin
                            state <= FETCH;
                            Done  <= 1'b0;
                            Busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (pop) begin
                        consumed <= consumed + COUNT_WIDTH'(1);
                        if (head != inf_point) begin
                            if (acc == inf_point) begin
                                acc <= head;
                            end else if (point_eq(acc, head)) begin
                                op_a        <= acc;
                                dbl_start_q <= 1'b1;
                                state       <= WAIT_DBL;
                            end else if (acc.x == head.x) begin
                                acc <= inf_point;
                            end else begin
                                op_a        <= acc;
                                op_b        <= head;
                                add_start_q <= 1'b1;
                                state       <= WAIT_ADD;
                            end
                        end
                    end else if ((fifo_count == '0) && (consumed == n_q)) begin
                        state <= DONE;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                    end
                end
                WAIT_ADD: begin
                    if (!add_start_q && add_done) begin
                        acc   <= add_result;
                        state <= FETCH;
                    end
                end
                WAIT_DBL: begin
                    if (!dbl_start_q && dbl_done) begin
                        acc   <= dbl_result;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msm_point_accumulator.sv
// Scoreboard bench for msm_point_accumulator. All terms are multiples of G=(3,6), which has order 5,
// so expected sums come from a hand-derived table of kG indexed by the term sum mod 5.
module tb_msm_point_accumulator;
    import elliptic_curve_structs::*;

    localparam int FIFO_DEPTH  = 4;
    localparam int COUNT_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   Reset_n;
    logic                   Start;
    logic [COUNT_WIDTH-1:0] N;
    logic                   In_valid;
    curve_point_t           In_point;
    logic                   In_ready;
    curve_point_t           Sum;
    logic                   Done;
    logic                   Busy;

    curve_point_t   exp_q[$];
    int             check_count = 0;
    int             pass_count  = 0;
    int             dbl_entries = 0;
    int             add_entries = 0;
    int             max_fifo    = 0;
    logic           in_ready_seen = 1'b0;
    msm_acc_state_t prev_state  = IDLE;
    int             terms[$];
    int             hs;
    int             stalls;
    int             extra;

    msm_point_accumulator #(.FIFO_DEPTH(FIFO_DEPTH), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .N        (N),
        .In_valid (In_valid),
        .In_point (In_point),
        .In_ready (In_ready),
        .Sum      (Sum),
        .Done     (Done),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    function automatic curve_point_t mult_g(input int k);
        case (((k % 5) + 5) % 5)
            1:       return '{x: 8'd3,  y: 8'd6};
            2:       return '{x: 8'd80, y: 8'd10};
            3:       return '{x: 8'd80, y: 8'd87};
            4:       return '{x: 8'd3,  y: 8'd91};
            default: return '{x: 8'd0,  y: 8'd0};
        endcase
    endfunction

    function automatic curve_point_t expected_sum(input int t[$]);
        int s = 0;
        foreach (t[i]) s += t[i];
        return mult_g(s);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Watches state entries and FIFO occupancy between edges.
    initial forever begin
        @(negedge clk);
        if (In_ready) in_ready_seen = 1'b1;
        if (dut.state == WAIT_DBL && prev_state != WAIT_DBL) dbl_entries++;
        if (dut.state == WAIT_ADD && prev_state != WAIT_ADD) add_entries++;
        if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
        prev_state = dut.state;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic beginRun(input int n, input int t[$]);
        exp_q.push_back(expected_sum(t));
        Start = 1'b1;
        N     = COUNT_WIDTH'(n);
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic applyStimulus(input int t[$], output int handshakes, output int stall_cycles);
        int idx    = 0;
        int cycles = 0;
        handshakes   = 0;
        stall_cycles = 0;
        while (idx < t.size() && cycles < 1000) begin
            In_valid = 1'b1;
            In_point = mult_g(t[idx]);
            if (In_ready) begin
                idx++;
                handshakes++;
            end else begin
                stall_cycles++;
            end
            @(negedge clk);
            cycles++;
        end
        In_valid = 1'b0;
        if (idx < t.size()) checkOutput("feed_timeout", 32'(idx), 32'(t.size()));
    endtask

    task automatic waitDone(input string tag);
        curve_point_t exp_sum;
        for (int i = 0; i < 2000 && !Done; i++) @(negedge clk);
        checkOutput({tag, "_done"}, 32'(Done), 32'd1);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_scoreboard"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp_sum = exp_q.pop_front();
            checkOutput({tag, "_sum"}, 32'(Sum), 32'(exp_sum));
        end
    endtask

    initial begin
        Reset_n  = 1'b0;
        Start    = 1'b0;
        N        = '0;
        In_valid = 1'b0;
        In_point = inf_point;

        repeat (3) @(negedge clk);
        checkOutput("reset_sum",      32'(Sum),          32'(inf_point));
        checkOutput("reset_done",     32'(Done),         32'd0);
        checkOutput("reset_busy",     32'(Busy),         32'd0);
        checkOutput("reset_in_ready", 32'(In_ready),     32'd0);
        checkOutput("reset_add_start",32'(dut.add_start),32'd1);
        Reset_n = 1'b1;
        @(negedge clk);

        // N=0 completes one cycle after Start with the point at infinity.
        in_ready_seen = 1'b0;
        terms = {};
        beginRun(0, terms);
        checkOutput("n0_done_1cycle", 32'(Done), 32'd1);
        waitDone("n0");
        repeat (2) @(negedge clk);
        checkOutput("n0_in_ready_never", 32'(in_ready_seen), 32'd0);

        // N=3: G, 2G, 3G, then extra offered terms must be refused.
        terms = {1, 2, 3};
        beginRun(3, terms);
        applyStimulus(terms, hs, stalls);
        checkOutput("n3_handshakes", 32'(hs), 32'd3);
        extra = 0;
        In_valid = 1'b1;
        In_point = mult_g(4);
        for (int i = 0; i < 20; i++) begin
            if (In_ready) extra++;
            @(negedge clk);
        end
        In_valid = 1'b0;
        checkOutput("n3_beyond_n", 32'(extra), 32'd0);
        waitDone("n3");
        checkOutput("n3_in_ready_low", 32'(In_ready), 32'd0);

        // Infinity, opposite-point and doubling exceptions without any addition.
        dbl_entries = 0;
        add_entries = 0;
        terms = {0, 1, 4, 1, 1};
        beginRun(5, terms);
        applyStimulus(terms, hs, stalls);
        waitDone("rules");
        checkOutput("rules_dbl_entries", 32'(dbl_entries), 32'd1);
        checkOutput("rules_add_entries", 32'(add_entries), 32'd0);

        // Back-to-back burst against the slow adder fills the FIFO.
        max_fifo = 0;
        terms = {1, 2, 1, 3, 2, 4, 1, 2};
        beginRun(8, terms);
        applyStimulus(terms, hs, stalls);
        waitDone("burst");
        checkOutput("burst_fifo_full", 32'(max_fifo), 32'(FIFO_DEPTH));
        checkOutput("burst_stalled",   32'(stalls > 0), 32'd1);
        checkOutput("burst_handshakes",32'(hs), 32'd8);

        // Reset pulse during an addition aborts the run.
        terms = {1, 2};
        beginRun(5, terms);
        applyStimulus(terms, hs, stalls);
        for (int i = 0; i < 200 && dut.state != WAIT_ADD; i++) @(negedge clk);
        checkOutput("abort_reached_wait_add", 32'(dut.state == WAIT_ADD), 32'd1);
        Reset_n = 1'b0;
        #1;
        checkOutput("abort_sum",      32'(Sum),      32'(inf_point));
        checkOutput("abort_done",     32'(Done),     32'd0);
        checkOutput("abort_busy",     32'(Busy),     32'd0);
        checkOutput("abort_in_ready", 32'(In_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        terms = {1, 2};
        beginRun(2, terms);
        applyStimulus(terms, hs, stalls);
        waitDone("after_abort");

        // Start while busy with a different N is ignored.
        terms = {1, 1, 1, 1};
        beginRun(4, terms);
        terms = {1, 1};
        applyStimulus(terms, hs, stalls);
        Start = 1'b1;
        N     = COUNT_WIDTH'(1);
        @(negedge clk);
        Start = 1'b0;
        checkOutput("busy_start_still_busy", 32'(Busy), 32'd1);
        applyStimulus(terms, hs, stalls);
        waitDone("busy_start");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
